// File: rtl/tff_mod_counter_pkg.sv
// -----------------------------------------------------------------------------
// tff_mod_counter_pkg
// Constants shared by the lab counter family.
//   DIR_UP / DIR_DOWN : encodings of the Up direction input.
//   MIN_MODULUS       : smallest count range a modulo counter may be built with.
// -----------------------------------------------------------------------------
package tff_mod_counter_pkg;

   // Direction encodings for the Up input.
   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // A modulo counter needs at least two states to count at all.
   localparam int unsigned MIN_MODULUS = 2;

endpackage : tff_mod_counter_pkg

// File: rtl/tff_cell.sv
// -----------------------------------------------------------------------------
// tff_cell
// Single-bit T flip-flop with asynchronous active-low clear.
// Ports:
//   T      in  : toggle request, the stored bit inverts on the rising edge.
//   Clock  in  : rising-edge clock.
//   Resetn in  : asynchronous active-low clear.
//   Q      out : stored bit.
// -----------------------------------------------------------------------------
module tff_cell (
   input  logic T,
   input  logic Clock,
   input  logic Resetn,
   output logic Q
);

   logic q_q;

   // NOTE: sequential state uses non-blocking assignment so every flop in the
   // design samples its inputs from the same pre-edge values.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         q_q <= 1'b0;
      end else if (T) begin
         q_q <= ~q_q;
      end
   end

   assign Q = q_q;

endmodule : tff_cell

// File: rtl/tff_mod_counter.sv
// -----------------------------------------------------------------------------
// tff_mod_counter
// Modulo-MODULUS up/down counter built from WIDTH T flip-flop cells.
// The next count N is computed combinationally and each cell is handed
// T = Q ^ N, so only bits that differ toggle; loads also go through toggles.
// Parameters:
//   WIDTH   : counter width in bits.
//   MODULUS : count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH.
// Ports:
//   Clock  in  : rising-edge clock.
//   Resetn in  : asynchronous active-low reset (Q=0, Err=0).
//   En     in  : count enable.
//   Up     in  : 1 = increment, 0 = decrement.
//   Load   in  : synchronous parallel load request, has priority over En.
//   D      in  : load value, rejected when D >= MODULUS.
//   Q      out : current count, registered.
//   TC     out : terminal count (combinational), high in the cycle before a
//                wrap; intended to drive En of the next cascaded stage.
//   Err    out : registered one-cycle pulse flagging a rejected load.
// -----------------------------------------------------------------------------
module tff_mod_counter
   import tff_mod_counter_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 10
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             En,
   input  logic             Up,
   input  logic             Load,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             TC,
   output logic             Err
);

   // ---------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ---------------------------------------------------------------------------
   localparam longint unsigned MOD_LIMIT = 64'(1) << WIDTH;

   generate
      if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
         $error("tff_mod_counter: WIDTH must be in 1..31");
      end
      if (longint'(MODULUS) < longint'(MIN_MODULUS) ||
          longint'(MODULUS) > MOD_LIMIT) begin : g_bad_modulus
         $error("tff_mod_counter: MODULUS must be in MIN_MODULUS..2**WIDTH");
      end
   endgenerate

   // Largest legal count, and MODULUS widened by one bit so that a
   // power-of-two modulus (which does not fit in WIDTH bits) still compares.
   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] count_q;   // assembled from the cell outputs
   logic [WIDTH-1:0] count_d;   // next-state value N
   logic [WIDTH-1:0] toggle;    // per-cell T inputs
   logic             err_q;
   logic             err_d;

   logic at_max;
   logic at_zero;
   logic load_ok;

   assign at_max  = (count_q == MAX_CNT);
   assign at_zero = (count_q == '0);
   assign load_ok = ({1'b0, D} < MOD_EXT);

   // ---------------------------------------------------------------------------
   // Next-state logic: Load > En > hold. Wrap uses the compare path for every
   // modulus, which for MODULUS = 2**WIDTH coincides with binary overflow.
   // ---------------------------------------------------------------------------
   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      count_d = count_q;
      err_d   = 1'b0;
      if (Load) begin
         if (load_ok) begin
            count_d = D;
         end else begin
            err_d = 1'b1;
         end
      end else if (En) begin
         if (Up == DIR_UP) begin
            count_d = at_max ? '0 : count_q + WIDTH'(1);
         end else begin
            count_d = at_zero ? MAX_CNT : count_q - WIDTH'(1);
         end
      end
   end

   // Only bits whose value changes are toggled.
   assign toggle = count_q ^ count_d;

   // ---------------------------------------------------------------------------
   // Bit cells
   // ---------------------------------------------------------------------------
   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_cell
         tff_cell u_cell (
            .T      (toggle[i]),
            .Clock  (Clock),
            .Resetn (Resetn),
            .Q      (count_q[i])
         );
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Rejected-load flag: high for exactly the cycle after a rejected load.
   // ---------------------------------------------------------------------------
   // NOTE: the asynchronous clear is needed so Err drops as soon as Resetn
   // falls, without waiting for a clock.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign Q   = count_q;
   assign Err = err_q;
   assign TC  = En & ~Load &
                (((Up == DIR_UP)   & at_max) |
                 ((Up == DIR_DOWN) & at_zero));

endmodule : tff_mod_counter

// File: doc/tff_mod_counter.md
Name: tff_mod_counter

Overview:
- Parametrised modulo up/down counter built from an array of T flip-flop bit cells.
- Each cell toggles when its T input is high; per-bit toggle enables are derived from the current count, direction and load request.
- Provides enable, direction control, synchronous parallel load with range check, and a cascadable terminal-count output.
- Serves as the general counter primitive for the lab datapaths (dividers, BCD digits, timers).

Parameters:
- WIDTH, 4: counter width in bits.
- MODULUS, 10: count range is 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2**WIDTH; elaboration fails outside this range.

Ports:
- Clock  input  1  rising-edge clock.
- Resetn  input  1  reset. One clock; reset is asynchronous and active-low.
- En  input  1  count enable.
- Up  input  1  direction: 1 = increment, 0 = decrement.
- Load  input  1  synchronous parallel load request.
- D  input  WIDTH  load value.
- Q  output  WIDTH  current count, registered.
- TC  output  1  terminal count, combinational.
- Err  output  1  registered one-cycle pulse flagging a rejected load.

Behaviour:
- Reset:
  - Resetn=0 forces Q=0 and Err=0 immediately, with no clock needed.
  - Reset mid-count discards the count.
  - While Resetn=0, all inputs are ignored.
  - The first active edge after Resetn rises counts normally.
- Priority at each rising Clock edge: Load > En > hold.
- Load=1, D < MODULUS: Q <= D; Err <= 0. En and Up are ignored this cycle.
- Load=1, D >= MODULUS: Q holds; Err <= 1 for exactly one cycle.
- Load=0, En=1, Up=1: Q <= (Q == MODULUS-1) ? 0 : Q+1.
- Load=0, En=1, Up=0: Q <= (Q == 0) ? MODULUS-1 : Q-1.
- Load=0, En=0: Q holds.
- Err returns to 0 on any edge without a rejected load.
- Latency: Q reflects the new value one edge after the request; no multi-cycle operations.
- TC = En & ~Load & ((Up & Q==MODULUS-1) | (~Up & Q==0)).
  - TC is high in the cycle before a wrap.
  - It is intended to drive the En of the next cascaded stage.
- Direction change (Up toggled while En=1) takes effect on the next edge; no extra cycle.
- Power-of-two modulus (MODULUS = 2**WIDTH): wrap is natural binary overflow and must produce the same Q sequence as the general compare path.
- Implementation:
  - Next-state value N is computed combinationally.
  - Cell i receives T[i] = Q[i] ^ N[i], so only differing bits toggle.
  - No cell is loaded directly; loads also go through toggles.
- No latches. TC is the only combinational output.

Decomposition:
- Shared constants file (header shared with other lab counters) holds:
  - direction encodings DIR_UP=1 and DIR_DOWN=0;
  - a MIN_MODULUS=2 constant used by the elaboration check.
- One sub-module, tff_cell:
  - single-bit T flip-flop with ports (T, Clock, Resetn, Q);
  - asynchronous active-low clear.
  - It is instantiated WIDTH times via generate.
- The range check and next-state logic stay in the top module.

Test Plan (WIDTH=4, MODULUS=10 unless noted):
1. Reset and up-count: Resetn=0 for 10 ns, then En=1, Up=1 for 12 edges.
   - Required Q: 1,2,...,9,0,1,2.
   - TC high only while Q=9.
   - Err=0 throughout.
2. Down-count wrap: load D=1, then En=1, Up=0 for 4 edges.
   - Required Q: 0,9,8,7.
   - TC high while Q=0.
3. Load priority and rejection:
   - Load=1, D=7 with En=1 -> Q=7, Err=0.
   - Next cycle Load=1, D=12 -> Q stays 7, Err=1 for one cycle, then 0.
4. Asynchronous reset mid-count: count to Q=5, then drop Resetn between edges.
   - Q=0 before the next rising edge.
   - Release -> counting resumes 1,2,...
5. Hold and direction change:
   - En=0 for 3 edges at Q=4 -> Q stays 4.
   - Then En=1, alternate Up 1/0 each edge -> Q: 5,4,5,4.
6. WIDTH=3, MODULUS=8: up-count 10 edges from reset.
   - Required Q: 1..7,0,1,2.
   - TC high at Q=7.
   - D=7 load accepted, Err=0.
